// File: rtl/shift_issue_stage.sv
// Purpose : issue stage ahead of the barrel shifter; decodes shift ops, picks operand/count, drops illegal ops.
// Latency : 1 cycle from accepted instruction to out_valid.
// Backpres: 2-entry main/skid buffer; in_ready is a flop (!skid full), no comb path from out_ready/in_valid.
module shift_issue_stage #(
    parameter int N  = 16,
    parameter int C  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    opcode,
    input  logic [1:0]    funct,
    input  logic [4:0]    imm,
    input  logic [N-1:0]  rs_data,
    input  logic [N-1:0]  rt_data,
    input  logic [2:0]    dst,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sh_in,
    output logic [C-1:0]  sh_cnt,
    output logic [1:0]    sh_op,
    output logic [2:0]    sh_dst,
    output logic [CW-1:0] illegal_cnt
);

    // One buffered instruction as the shifter sees it.
    typedef struct packed {
        logic [N-1:0] dat;
        logic [C-1:0] cnt;
        logic [1:0]   op;
        logic [2:0]   dst;
    } entry_t;

    // Buffer occupancy: nothing, main only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MAIN  = 2'b01,
        ST_FULL  = 2'b10
    } occ_e;

    localparam logic [4:0] OPC_ROLI = 5'b10100;
    localparam logic [4:0] OPC_SLLI = 5'b10101;
    localparam logic [4:0] OPC_RORI = 5'b10110;
    localparam logic [4:0] OPC_SRLI = 5'b10111;
    localparam logic [4:0] OPC_RFMT = 5'b11010;

    occ_e    state;
    occ_e    state_nxt;
    entry_t  main_dat;
    entry_t  skid_dat;
    entry_t  dec_dat;
    logic    dec_legal;

    logic    main_vld;
    logic    skid_vld;
    logic    acc_vld;
    logic    push_vld;
    logic    pop_vld;
    logic    ill_vld;

    logic    load_main_dec;
    logic    load_main_skid;
    logic    load_skid_dec;

    // imm[4] and the upper rt_data bits never feed the count.
    logic    unused_bits;
    assign unused_bits = ^{imm[4:C], rt_data[N-1:C]};

    // Decode opcode/funct into shifter op and count source; flag anything else as illegal.
    always_comb begin
        dec_legal   = 1'b1;
        dec_dat.dat = rs_data;
        dec_dat.cnt = imm[C-1:0];
        dec_dat.op  = 2'b00;
        dec_dat.dst = dst;
        case (opcode)
            OPC_ROLI: dec_dat.op = 2'b00;
            OPC_SLLI: dec_dat.op = 2'b01;
            OPC_RORI: dec_dat.op = 2'b10;
            OPC_SRLI: dec_dat.op = 2'b11;
            OPC_RFMT: begin
                dec_dat.op  = funct;
                dec_dat.cnt = rt_data[C-1:0];
            end
            default:  dec_legal = 1'b0;
        endcase
    end

    assign main_vld = (state != ST_EMPTY);
    assign skid_vld = (state == ST_FULL);

    // in_ready is derived purely from registered occupancy.
    assign in_ready = !skid_vld;

    assign acc_vld  = in_valid && in_ready;
    // A flush swallows whatever is accepted in the same cycle.
    assign push_vld = acc_vld && dec_legal && !flush;
    // Illegal ops are counted even when a flush drops everything else.
    assign ill_vld  = acc_vld && !dec_legal;
    assign pop_vld  = main_vld && out_ready;

    // Next occupancy and which storage slot loads from where.
    always_comb begin
        state_nxt      = state;
        load_main_dec  = 1'b0;
        load_main_skid = 1'b0;
        load_skid_dec  = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push_vld) begin
                        state_nxt     = ST_MAIN;
                        load_main_dec = 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (pop_vld && push_vld) begin
                        load_main_dec = 1'b1;
                    end else if (push_vld) begin
                        state_nxt     = ST_FULL;
                        load_skid_dec = 1'b1;
                    end else if (pop_vld) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop_vld) begin
                        state_nxt      = ST_MAIN;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Occupancy and entry storage; reset clears data so sh_* read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            main_dat <= '0;
            skid_dat <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_dec) begin
                main_dat <= dec_dat;
            end else if (load_main_skid) begin
                main_dat <= skid_dat;
            end
            if (load_skid_dec) begin
                skid_dat <= dec_dat;
            end
        end
    end

    // Saturating count of dropped non-shift instructions; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (ill_vld && (illegal_cnt != {CW{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign out_valid = main_vld;
    assign sh_in     = main_dat.dat;
    assign sh_cnt    = main_dat.cnt;
    assign sh_op     = main_dat.op;
    assign sh_dst    = main_dat.dst;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Purpose : directed bench for shift_issue_stage with hand-computed expectations.
// Latency : checks sampled 1 time unit after each rising edge.
// Backpres: exercises skid fill/drain, flush and reset while stalled.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [1:0]  funct;
    logic [4:0]  imm;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [2:0]  dst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sh_in;
    logic [3:0]  sh_cnt;
    logic [1:0]  sh_op;
    logic [2:0]  sh_dst;
    logic [7:0]  illegal_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    shift_issue_stage #(.N(16), .C(4), .CW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .imm         (imm),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .dst         (dst),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sh_in       (sh_in),
        .sh_cnt      (sh_cnt),
        .sh_op       (sh_op),
        .sh_dst      (sh_dst),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference barrel shifter: 00 rotl, 01 sll, 10 rotr, 11 srl.
    function automatic logic [15:0] shf(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
        logic [31:0] t;
        logic [15:0] r;
        r = 16'h0000;
        case (op)
            2'b00: begin t = {d, d} << c; r = t[31:16]; end
            2'b01: r = d << c;
            2'b10: begin t = {d, d} >> c; r = t[15:0]; end
            default: r = d >> c;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] opc, input logic [1:0] f,
                         input logic [4:0] im, input logic [15:0] rs, input logic [15:0] rt,
                         input logic [2:0] d);
        in_valid = v;
        opcode   = opc;
        funct    = f;
        imm      = im;
        rs_data  = rs;
        rt_data  = rt;
        dst      = d;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_out_valid"},   32'(out_valid),   0);
        check({pfx, "_in_ready"},    32'(in_ready),    1);
        check({pfx, "_sh_in"},       32'(sh_in),       0);
        check({pfx, "_sh_cnt"},      32'(sh_cnt),      0);
        check({pfx, "_sh_op"},       32'(sh_op),       0);
        check({pfx, "_sh_dst"},      32'(sh_dst),      0);
        check({pfx, "_illegal_cnt"}, 32'(illegal_cnt), 0);
    endtask

    initial begin
        logic saw_valid;

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);

        // Reset state
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b0;

        // SLLI single op, imm[4] ignored
        drive(1'b1, 5'b10101, 2'b11, 5'b10011, 16'h00F1, 16'hFFFF, 3'd5);
        step();
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        check("slli_valid", 32'(out_valid), 1);
        check("slli_in",    32'(sh_in),     'h00F1);
        check("slli_cnt",   32'(sh_cnt),    3);
        check("slli_op",    32'(sh_op),     1);
        check("slli_dst",   32'(sh_dst),    5);
        check("slli_shift", 32'(shf(sh_in, sh_cnt, sh_op)), 'h0788);
        out_ready = 1'b1;
        step();
        check("slli_pop_empty", 32'(out_valid), 0);

        // R-format: count comes from rt_data[3:0], op from funct
        out_ready = 1'b0;
        drive(1'b1, 5'b11010, 2'b10, 5'b00111, 16'h8001, 16'hFFF4, 3'd2);
        step();
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        check("rfmt_op",    32'(sh_op),  2);
        check("rfmt_cnt",   32'(sh_cnt), 4);
        check("rfmt_shift", 32'(shf(sh_in, sh_cnt, sh_op)), 'h1800);
        out_ready = 1'b1;
        step();
        check("rfmt_pop_empty", 32'(out_valid), 0);

        // Skid fill under backpressure, then in-order drain
        out_ready = 1'b0;
        drive(1'b1, 5'b10100, 2'b00, 5'b00001, 16'h1234, 16'h0000, 3'd1);
        step();
        check("skid_first_in_ready", 32'(in_ready), 1);
        drive(1'b1, 5'b10111, 2'b00, 5'b00010, 16'hABCD, 16'h0000, 3'd2);
        step();
        check("skid_full_in_ready", 32'(in_ready), 0);
        drive(1'b1, 5'b10101, 2'b00, 5'b00101, 16'h5555, 16'h0000, 3'd3);
        step();
        check("skid_held_in_ready", 32'(in_ready), 0);
        check("skid_held_dst",      32'(sh_dst),   1);
        check("skid_held_in",       32'(sh_in),    'h1234);
        check("skid_held_op",       32'(sh_op),    0);
        check("skid_held_cnt",      32'(sh_cnt),   1);
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        out_ready = 1'b1;
        step();
        check("drain1_valid",    32'(out_valid), 1);
        check("drain1_in_ready", 32'(in_ready),  1);
        check("drain1_dst",      32'(sh_dst),    2);
        check("drain1_in",       32'(sh_in),     'hABCD);
        check("drain1_op",       32'(sh_op),     3);
        check("drain1_cnt",      32'(sh_cnt),    2);
        step();
        check("drain2_empty", 32'(out_valid), 0);

        // Simultaneous pop and push with one entry replaces main
        drive(1'b1, 5'b10110, 2'b00, 5'b00110, 16'h0F0F, 16'h0000, 3'd4);
        step();
        drive(1'b1, 5'b10100, 2'b00, 5'b01000, 16'hF00F, 16'h0000, 3'd6);
        step();
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        check("poppush_valid",    32'(out_valid), 1);
        check("poppush_dst",      32'(sh_dst),    6);
        check("poppush_in_ready", 32'(in_ready),  1);
        step();

        // Illegal opcodes are dropped and counted
        saw_valid = 1'b0;
        drive(1'b1, 5'b00000, 2'b00, 5'b00000, 16'h1111, 16'h0000, 3'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        check("illegal_cnt3",   32'(illegal_cnt), 3);
        check("illegal_novld3", 32'(saw_valid),   0);

        // Flush with both entries full and a legal op presented
        out_ready = 1'b0;
        drive(1'b1, 5'b10101, 2'b00, 5'b00001, 16'h0001, 16'h0000, 3'd1);
        step();
        drive(1'b1, 5'b10101, 2'b00, 5'b00010, 16'h0002, 16'h0000, 3'd2);
        step();
        check("flush_pre_in_ready", 32'(in_ready), 0);
        drive(1'b1, 5'b10101, 2'b00, 5'b00011, 16'h0003, 16'h0000, 3'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        check("flush_full_valid",    32'(out_valid), 0);
        check("flush_full_in_ready", 32'(in_ready),  1);
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("flush_never_appears", 32'(saw_valid), 0);

        // Flush discards an op accepted in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 5'b10111, 2'b00, 5'b00001, 16'h00AA, 16'h0000, 3'd3);
        step();
        drive(1'b1, 5'b10111, 2'b00, 5'b00010, 16'h00BB, 16'h0000, 3'd5);
        flush = 1'b1;
        step();
        check("flush_acc_valid",    32'(out_valid), 0);
        check("flush_acc_in_ready", 32'(in_ready),  1);

        // Illegal op accepted during flush still counts
        drive(1'b1, 5'b11111, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        step();
        flush = 1'b0;
        check("flush_illegal_cnt", 32'(illegal_cnt), 4);
        check("flush_illegal_vld", 32'(out_valid),    0);

        // Saturation at 255
        for (int i = 0; i < 260; i++) begin
            step();
        end
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        check("illegal_sat", 32'(illegal_cnt), 255);
        check("illegal_sat_vld", 32'(out_valid), 0);

        // Reset while both entries are full and stalled
        out_ready = 1'b0;
        drive(1'b1, 5'b10100, 2'b00, 5'b00111, 16'hBEEF, 16'h0000, 3'd7);
        step();
        drive(1'b1, 5'b10110, 2'b00, 5'b00101, 16'hCAFE, 16'h0000, 3'd6);
        step();
        check("stall_pre_in_ready", 32'(in_ready), 0);
        drive(1'b0, 5'b00000, 2'b00, 5'b00000, 16'h0000, 16'h0000, 3'd0);
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        step();
        check("post_rst_valid", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Execute-side issue stage directly upstream of the barrel shifter. Accepts decoded shift instructions from decode over a valid/ready handshake.
- Selects the operand and the shift count (5-bit immediate or Rt register), and maps the opcode/funct to the shifter's 2-bit Op.
- Presents registered In/Cnt/Op to the shifter through a 2-entry skid buffer, so backpressure never creates a combinational ready path back to decode.
- Also supports pipeline flush and counts dropped non-shift instructions.

Parameters:
- N, 16, data width (matches shifter In/Out)
- C, 4, shift-count width (matches shifter Cnt)
- CW, 8, width of the illegal-op counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  decode has an instruction this cycle
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- opcode  input  5  instruction bits [15:11]
- funct  input  2  instruction bits [1:0], used only for opcode 11010
- imm  input  5  instruction bits [4:0]
- rs_data  input  N  value to be shifted
- rt_data  input  N  register count source; only [C-1:0] used
- dst  input  3  destination register tag, carried through
- flush  input  1  discard all buffered entries
- out_valid  output  1  sh_* fields valid
- out_ready  input  1  downstream (shifter/writeback) accepts
- sh_in  output  N  operand to shifter In
- sh_cnt  output  C  count to shifter Cnt
- sh_op  output  2  shifter Op
- sh_dst  output  3  tag aligned with sh_in
- illegal_cnt  output  CW  saturating count of dropped non-shift opcodes

Behaviour:
- Opcode decode (combinational on inputs):
  - 10100 ROLI → op 00, cnt = imm[3:0]
  - 10101 SLLI → op 01, cnt = imm[3:0]
  - 10110 RORI → op 10, cnt = imm[3:0]
  - 10111 SRLI → op 11, cnt = imm[3:0]
  - 11010 (R-format) → op = funct, cnt = rt_data[3:0]
  - Any other opcode is illegal.
- Shifter Op semantics (for reference in checking): 00 rotate left, 01 shift left zero-fill, 10 rotate right, 11 shift right logical. imm[4] is ignored.
- Accept occurs when in_valid && in_ready.
  - Accepted legal op: enqueued.
  - Accepted illegal op: not enqueued; illegal_cnt increments by 1, saturating at 2^CW-1.
- Storage is two entries: main (drives sh_*) and skid. out_valid = main_valid.
- Per-cycle update, with pop = out_valid && out_ready and push = legal accept:
  - Empty, push → main loaded next cycle. Latency from accept to out_valid is 1 cycle.
  - Main only, pop and push → main replaced with the new entry.
  - Main only, push without pop → new entry goes to skid; in_ready drops next cycle.
  - Main only, pop without push → empty.
  - Both full, pop → skid moves to main; skid cleared; in_ready rises next cycle.
  - Both full: push cannot occur because in_ready = 0.
- Ordering: strictly FIFO; sh_* fields change only on a pop or when main is loaded from empty.
- When out_valid = 1 and out_ready = 0, sh_in/sh_cnt/sh_op/sh_dst hold stable.
- Flush:
  - Next cycle, main_valid = skid_valid = 0.
  - Any same-cycle accept is discarded, and an illegal op accepted that cycle is still counted.
  - illegal_cnt is not cleared by flush.
- Reset, synchronous, and also when asserted mid-transfer:
  - out_valid = 0, in_ready = 1, sh_in = 0, sh_cnt = 0, sh_op = 00, sh_dst = 0, illegal_cnt = 0.
  - rst has priority over flush and over the handshake.
- Data fields of invalid entries are don't-care except after reset, where they are 0.
- No combinational path from out_ready or in_valid to in_ready.

Test Plan:
- Reset then single op: rst for 2 cycles, then SLLI with rs_data = 16'h00F1, imm = 5'b10011 → 1 cycle later out_valid = 1, sh_in = 16'h00F1, sh_cnt = 3, sh_op = 01. With out_ready = 1, the shifter output is 16'h0788.
- R-format count source: opcode 11010, funct 10, rs_data = 16'h8001, rt_data = 16'hFFF4 → sh_op = 10, sh_cnt = 4. The shifter output is 16'h1800.
- Backpressure and skid: out_ready = 0, push ROLI then SRLI on back-to-back cycles.
  - in_ready goes 0 after the second accept, and a third in_valid is held off.
  - Raise out_ready: ROLI pops, then SRLI pops, in order.
  - in_ready returns to 1 the cycle after the first pop.
- Illegal opcodes: send opcode 00000 three times, then 257 more with CW = 8 → out_valid never asserts, and illegal_cnt = 3, then saturates at 255.
- Flush with both entries full: assert flush together with an in_valid legal op → next cycle out_valid = 0, in_ready = 1, and the flushed op never appears.
- Reset mid-stall: both entries full, out_ready = 0, assert rst → next cycle all outputs are at reset values and illegal_cnt = 0.
